bt_update_queue: RTL and testbench

- Sink for the BTUpdate stream produced by the branch-capable integer ALUs, which emit one BTUpdate per mispredicted indirect jump/call.
- Collects up to NUM_IN updates per cycle into a small circular FIFO.
- Drains one update per cycle to the branch target buffer under a valid/ready handshake.
- Decouples ALU resolution timing from BTB write-port availability. BTB training is a hint, so overflow drops updates and counts them; the queue never stalls the ALUs.

---
 rtl/bt_update_queue_pkg.sv | 13 +
 rtl/bt_update_queue.sv | 147 ++++++++++++++
 tb/tb_bt_update_queue.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bt_update_queue_pkg.sv
// Shared types for the branch-target update queue: the BTUpdate payload and
// the default queue depth used when instantiating bt_update_queue.
package bt_update_queue_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] src;
    logic [31:0] dst;
  } BTUpdate;

  localparam int BTUQ_DEPTH = 4;

endpackage

// File: rtl/bt_update_queue.sv
// Queues BTB training updates from the branch ALUs and drains one per cycle to the BTB.
// Optional macro BTUQ_DEDUP_EN merges updates whose src matches a queued or same-cycle entry.
module bt_update_queue
  import bt_update_queue_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int DEPTH  = BTUQ_DEPTH,
  parameter int CNT_W  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_IN*$bits(BTUpdate)-1:0] IN_btUpdate,
  input  logic                              IN_clear,
  input  logic                              IN_btbReady,
  output logic [$bits(BTUpdate)-1:0]        OUT_btUpdate,
  output logic [CNT_W-1:0]                  OUT_dropCnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int UPD_W = $bits(BTUpdate);

  BTUpdate           entries [DEPTH];
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [OCC_W-1:0]  count;
  logic [CNT_W-1:0]  dropCnt;

  BTUpdate           inUpd [NUM_IN];
  BTUpdate           head;
  logic              pop;

  logic [OCC_W-1:0]  cap;
  logic [OCC_W-1:0]  nPushed;
  logic [OCC_W-1:0]  nDropped;
  logic [DEPTH-1:0]  wrEn;
  BTUpdate           wrData [DEPTH];
  logic [PTR_W-1:0]  slot;
  logic              hit;
  logic [CNT_W:0]    dropSum;
  logic [CNT_W-1:0]  dropNext;

`ifdef BTUQ_DEDUP_EN
  logic [DEPTH-1:0]  live;
  logic [PTR_W-1:0]  offset;
`endif

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      inUpd[i] = IN_btUpdate[i*UPD_W +: UPD_W];
    end
  end

  assign pop = (count != '0) && IN_btbReady;

  always_comb begin
    head       = entries[rdPtr];
    head.valid = (count != '0);
  end

  assign OUT_btUpdate = head;
  assign OUT_dropCnt  = dropCnt;

  // Slot allocation: valid inputs in port order claim consecutive slots from
  // wrPtr until capacity runs out; the rest are dropped.
  always_comb begin
    cap      = OCC_W'(DEPTH) - count + OCC_W'(pop);
    nPushed  = '0;
    nDropped = '0;
    wrEn     = '0;
    slot     = '0;
    hit      = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      wrData[k] = entries[k];
    end
`ifdef BTUQ_DEDUP_EN
    offset = '0;
    for (int k = 0; k < DEPTH; k++) begin
      offset  = PTR_W'(k) - rdPtr;
      live[k] = ({1'b0, offset} < count) && !(pop && (PTR_W'(k) == rdPtr));
    end
`endif
    for (int i = 0; i < NUM_IN; i++) begin
      if (inUpd[i].valid) begin
        hit = 1'b0;
`ifdef BTUQ_DEDUP_EN
        // A live slot with the same src (queued or claimed earlier this cycle) takes the newer payload.
        for (int k = 0; k < DEPTH; k++) begin
          if (!hit && live[k] && (wrData[k].src == inUpd[i].src)) begin
            hit       = 1'b1;
            wrEn[k]   = 1'b1;
            wrData[k] = inUpd[i];
          end
        end
`endif
        if (!hit) begin
          if (nPushed < cap) begin
            slot         = wrPtr + PTR_W'(nPushed);
            wrEn[slot]   = 1'b1;
            wrData[slot] = inUpd[i];
            nPushed      = nPushed + OCC_W'(1);
`ifdef BTUQ_DEDUP_EN
            live[slot]   = 1'b1;
`endif
          end else begin
            nDropped = nDropped + OCC_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    dropSum  = {1'b0, dropCnt} + (CNT_W + 1)'(nDropped);
    dropNext = dropSum[CNT_W] ? '1 : dropSum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      count   <= '0;
      dropCnt <= '0;
    end else if (IN_clear) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      rdPtr   <= rdPtr + PTR_W'(pop);
      wrPtr   <= wrPtr + PTR_W'(nPushed);
      count   <= count + nPushed - OCC_W'(pop);
      dropCnt <= dropNext;
    end
  end

  // Payload storage carries no reset; only occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !IN_clear) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (wrEn[k]) begin
          entries[k] <= wrData[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_bt_update_queue.sv
// Directed self-checking bench for bt_update_queue (NUM_IN = 2, DEPTH = 4, CNT_W = 16).
// Expectations follow BTUQ_DEDUP_EN when it is defined for the whole compile.
module tb_bt_update_queue;
  import bt_update_queue_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          ready;
  BTUpdate       in0;
  BTUpdate       in1;
  logic [129:0]  inW;
  logic [64:0]   outW;
  BTUpdate       outU;
  logic [15:0]   dropCnt;

  int nTests = 0;
  int nFail  = 0;
  int expDrop = 0;

  assign inW  = {in1, in0};
  assign outU = outW;

  bt_update_queue #(.NUM_IN(2), .DEPTH(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .IN_btUpdate  (inW),
    .IN_clear     (clear),
    .IN_btbReady  (ready),
    .OUT_btUpdate (outW),
    .OUT_dropCnt  (dropCnt)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v0, input logic [31:0] s0, input logic [31:0] d0,
                               input logic v1, input logic [31:0] s1, input logic [31:0] d1);
    in0 = '{valid: v0, src: s0, dst: d0};
    in1 = '{valid: v1, src: s1, dst: d1};
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; clear = 1'b0; ready = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    step; step;
    nTests++;
    if (outU.valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid got %b want 0", outU.valid); end
    nTests++;
    if (dropCnt !== 16'd0) begin nFail++; $display("[TB] FAIL reset_dropCnt got %0d want 0", dropCnt); end
    rst = 1'b0;
    step;
  endtask

  task automatic test_single_push;
    ready = 1'b1;
    applyStimulus(1, 32'h8000_0010, 32'h8000_2000, 0, 0, 0);
    step;
    applyStimulus(0, 0, 0, 0, 0, 0);
    nTests++;
    if (outU !== BTUpdate'({1'b1, 32'h8000_0010, 32'h8000_2000}))
      begin nFail++; $display("[TB] FAIL single_head got %h want valid 80000010/80002000", outU); end
    step;
    nTests++;
    if (outU.valid !== 1'b0) begin nFail++; $display("[TB] FAIL single_empty got %b want 0", outU.valid); end
  endtask

  task automatic test_fill_overflow;
    ready = 1'b0;
    applyStimulus(1, 32'hA0, 32'h1A0, 1, 32'hA1, 32'h1A1); step;
    applyStimulus(1, 32'hB0, 32'h1B0, 1, 32'hB1, 32'h1B1); step;
    applyStimulus(1, 32'hC0, 32'h1C0, 1, 32'hC1, 32'h1C1); step;
    applyStimulus(0, 0, 0, 0, 0, 0);
    expDrop = expDrop + 2;
    nTests++;
    if (dropCnt !== 16'(expDrop)) begin nFail++; $display("[TB] FAIL overflow_drop got %0d want %0d", dropCnt, expDrop); end
    nTests++;
    if (outU !== BTUpdate'({1'b1, 32'hA0, 32'h1A0})) begin nFail++; $display("[TB] FAIL overflow_head got %h want A0", outU); end
    step;
    nTests++;
    if (outU !== BTUpdate'({1'b1, 32'hA0, 32'h1A0})) begin nFail++; $display("[TB] FAIL stall_head got %h want A0", outU); end
  endtask

  task automatic test_full_pop;
    logic [31:0] expSrc [4];
    expSrc[0] = 32'hA1; expSrc[1] = 32'hB0; expSrc[2] = 32'hB1; expSrc[3] = 32'hD0;
    ready = 1'b1;
    applyStimulus(1, 32'hD0, 32'h1D0, 1, 32'hD1, 32'h1D1);
    step;
    applyStimulus(0, 0, 0, 0, 0, 0);
    expDrop = expDrop + 1;
    nTests++;
    if (dropCnt !== 16'(expDrop)) begin nFail++; $display("[TB] FAIL fullpop_drop got %0d want %0d", dropCnt, expDrop); end
    for (int i = 0; i < 4; i++) begin
      nTests++;
      if (outU !== BTUpdate'({1'b1, expSrc[i], expSrc[i] + 32'h100}))
        begin nFail++; $display("[TB] FAIL fullpop_drain%0d got %h want src %h", i, outU, expSrc[i]); end
      step;
    end
    nTests++;
    if (outU.valid !== 1'b0) begin nFail++; $display("[TB] FAIL fullpop_empty got %b want 0", outU.valid); end
  endtask

  task automatic test_clear;
    ready = 1'b0;
    applyStimulus(1, 32'hE0, 32'h1E0, 1, 32'hE1, 32'h1E1); step;
    applyStimulus(1, 32'hE2, 32'h1E2, 0, 0, 0); step;
    clear = 1'b1;
    applyStimulus(1, 32'hF0, 32'h1F0, 0, 0, 0); step;
    clear = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    nTests++;
    if (outU.valid !== 1'b0) begin nFail++; $display("[TB] FAIL clear_valid got %b want 0", outU.valid); end
    nTests++;
    if (dropCnt !== 16'(expDrop)) begin nFail++; $display("[TB] FAIL clear_drop got %0d want %0d", dropCnt, expDrop); end
    applyStimulus(1, 32'h60, 32'h160, 0, 0, 0); step;
    applyStimulus(0, 0, 0, 0, 0, 0);
    nTests++;
    if (outU !== BTUpdate'({1'b1, 32'h60, 32'h160})) begin nFail++; $display("[TB] FAIL clear_repush got %h want 60", outU); end
    ready = 1'b1;
    step;
    nTests++;
    if (outU.valid !== 1'b0) begin nFail++; $display("[TB] FAIL clear_drain got %b want 0", outU.valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] expSrc [6];
    expSrc[0] = 32'h70; expSrc[1] = 32'h71; expSrc[2] = 32'h72;
    expSrc[3] = 32'h73; expSrc[4] = 32'h74; expSrc[5] = 32'h75;
    ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 32'h70 + 32'(2*c), 32'h170 + 32'(2*c), 1, 32'h71 + 32'(2*c), 32'h171 + 32'(2*c));
      step;
      nTests++;
      if (outU !== BTUpdate'({1'b1, expSrc[c], expSrc[c] + 32'h100}))
        begin nFail++; $display("[TB] FAIL b2b_push%0d got %h want src %h", c, outU, expSrc[c]); end
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int c = 3; c < 6; c++) begin
      step;
      nTests++;
      if (outU !== BTUpdate'({1'b1, expSrc[c], expSrc[c] + 32'h100}))
        begin nFail++; $display("[TB] FAIL b2b_drain%0d got %h want src %h", c, outU, expSrc[c]); end
    end
    step;
    nTests++;
    if (outU.valid !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_empty got %b want 0", outU.valid); end
    nTests++;
    if (dropCnt !== 16'(expDrop)) begin nFail++; $display("[TB] FAIL b2b_drop got %0d want %0d", dropCnt, expDrop); end
  endtask

  task automatic test_port_skip;
    ready = 1'b0;
    applyStimulus(0, 32'h90, 32'h190, 1, 32'h91, 32'h191); step;
    applyStimulus(0, 0, 0, 0, 0, 0);
    nTests++;
    if (outU !== BTUpdate'({1'b1, 32'h91, 32'h191})) begin nFail++; $display("[TB] FAIL skip_head got %h want 91", outU); end
    ready = 1'b1;
    step;
    nTests++;
    if (outU.valid !== 1'b0) begin nFail++; $display("[TB] FAIL skip_empty got %b want 0", outU.valid); end
  endtask

  task automatic test_wrap;
    ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 0, 0, 0);
      step;
      nTests++;
      if (outU !== BTUpdate'({1'b1, 32'h1000 + 32'(i), 32'h2000 + 32'(i)}))
        begin nFail++; $display("[TB] FAIL wrap%0d got %h want src %h", i, outU, 32'h1000 + 32'(i)); end
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    step;
    nTests++;
    if (outU.valid !== 1'b0) begin nFail++; $display("[TB] FAIL wrap_empty got %b want 0", outU.valid); end
  endtask

  task automatic test_dedup;
    ready = 1'b0;
    applyStimulus(1, 32'h100, 32'h200, 0, 0, 0); step;
    applyStimulus(1, 32'h100, 32'h300, 0, 0, 0); step;
    applyStimulus(0, 0, 0, 0, 0, 0);
`ifdef BTUQ_DEDUP_EN
    nTests++;
    if (outU !== BTUpdate'({1'b1, 32'h100, 32'h300})) begin nFail++; $display("[TB] FAIL dedup_head got %h want dst 300", outU); end
    ready = 1'b1;
    step;
    nTests++;
    if (outU.valid !== 1'b0) begin nFail++; $display("[TB] FAIL dedup_single got %b want 0", outU.valid); end
    ready = 1'b0;
    applyStimulus(1, 32'h40, 32'h1, 1, 32'h40, 32'h2); step;
    applyStimulus(0, 0, 0, 0, 0, 0);
    nTests++;
    if (outU !== BTUpdate'({1'b1, 32'h40, 32'h2})) begin nFail++; $display("[TB] FAIL dedup_same got %h want dst 2", outU); end
    ready = 1'b1;
    step;
    nTests++;
    if (outU.valid !== 1'b0) begin nFail++; $display("[TB] FAIL dedup_same_single got %b want 0", outU.valid); end
`else
    nTests++;
    if (outU !== BTUpdate'({1'b1, 32'h100, 32'h200})) begin nFail++; $display("[TB] FAIL dup_first got %h want dst 200", outU); end
    ready = 1'b1;
    step;
    nTests++;
    if (outU !== BTUpdate'({1'b1, 32'h100, 32'h300})) begin nFail++; $display("[TB] FAIL dup_second got %h want dst 300", outU); end
    step;
    nTests++;
    if (outU.valid !== 1'b0) begin nFail++; $display("[TB] FAIL dup_empty got %b want 0", outU.valid); end
`endif
    nTests++;
    if (dropCnt !== 16'(expDrop)) begin nFail++; $display("[TB] FAIL dedup_drop got %0d want %0d", dropCnt, expDrop); end
  endtask

  task automatic test_saturation;
    int startDrop;
    startDrop = expDrop;
    ready = 1'b0;
    for (int i = 0; i < 32800; i++) begin
      applyStimulus(1, 32'h0100_0000 + 32'(2*i), 32'h0, 1, 32'h0100_0001 + 32'(2*i), 32'h0);
      step;
      if (i == 100) begin
        nTests++;
        if (dropCnt !== 16'(startDrop + 2*99))
          begin nFail++; $display("[TB] FAIL sat_mid got %0d want %0d", dropCnt, startDrop + 2*99); end
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    nTests++;
    if (dropCnt !== 16'hFFFF) begin nFail++; $display("[TB] FAIL sat_final got %0d want 65535", dropCnt); end
    nTests++;
    if (outU !== BTUpdate'({1'b1, 32'h0100_0000, 32'h0})) begin nFail++; $display("[TB] FAIL sat_head got %h want 01000000", outU); end
  endtask

  initial begin
    test_reset;
    test_single_push;
    test_fill_overflow;
    test_full_pop;
    test_clear;
    test_back_to_back;
    test_port_skip;
    test_wrap;
    test_dedup;
    test_saturation;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
